// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// The result is computed at launch into a shadow register and committed after a fixed latency.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A1,
    input  logic [31:0] A2,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic        HiWrite,
    input  logic        LoWrite,
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    // state | meaning
    // IDLE  | no operation in flight; Start and MTHI/MTLO accepted
    // RUN   | operation in flight; cnt counts down to the commit edge
    typedef enum logic {IDLE, RUN} state_t;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [63:0]   res, res_nxt;
    logic          res_wr, res_wr_nxt;
    logic          load, commit, mt_en;

    // ---- result precompute ----
    logic signed [63:0] mul_s;
    logic [63:0]        mul_u;
    logic [31:0]        a_abs, b_abs, b_abs_safe, b_u_safe;
    logic [31:0]        sq_mag, sr_mag, sq, sr, uq, ur;

    assign mul_s = $signed({{32{A1[31]}}, A1}) * $signed({{32{A2[31]}}, A2});
    assign mul_u = {32'd0, A1} * {32'd0, A2};

    // Divide by zero is replaced by a divisor of 1 so no X reaches the shadow;
    // the result is then discarded via res_wr.
    assign a_abs      = A1[31] ? (~A1 + 32'd1) : A1;
    assign b_abs      = A2[31] ? (~A2 + 32'd1) : A2;
    assign b_abs_safe = (b_abs == 32'd0) ? 32'd1 : b_abs;
    assign b_u_safe   = (A2 == 32'd0) ? 32'd1 : A2;

    assign sq_mag = a_abs / b_abs_safe;
    assign sr_mag = a_abs % b_abs_safe;
    assign sq     = (A1[31] ^ A2[31]) ? (~sq_mag + 32'd1) : sq_mag;
    assign sr     = A1[31] ? (~sr_mag + 32'd1) : sr_mag;
    assign uq     = A1 / b_u_safe;
    assign ur     = A1 % b_u_safe;

    always_comb begin
        res_nxt    = res;
        res_wr_nxt = 1'b1;
        case (MDOp)
            2'b00:   res_nxt = mul_s;
            2'b01:   res_nxt = mul_u;
            2'b10:   res_nxt = {sr, sq};
            2'b11:   res_nxt = {ur, uq};
            default: res_nxt = res;
        endcase
        if (MDOp[1] && (A2 == 32'd0))
            res_wr_nxt = 1'b0;
    end

    // ---- control FSM ----
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        commit    = 1'b0;
        mt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = MDOp[1] ? DIV_LD : MULT_LD;
                end else begin
                    mt_en = 1'b1;
                end
            end
            RUN: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res    <= '0;
            res_wr <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
        end else begin
            if (load) begin
                res    <= res_nxt;
                res_wr <= res_wr_nxt;
            end
            if (commit && res_wr) begin
                Hi <= res[63:32];
                Lo <= res[31:0];
            end else if (mt_en) begin
                if (HiWrite) Hi <= A1;
                if (LoWrite) Lo <= A1;
            end
        end
    end

    assign Busy = (state == RUN);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, corner sequences, random vs. arithmetic model.
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] A1, A2;
    logic        Start, HiWrite, LoWrite;
    logic [1:0]  MDOp;
    logic        Busy;
    logic [31:0] Hi, Lo;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .A1(A1), .A2(A2), .Start(Start), .MDOp(MDOp),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .Busy(Busy), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Plain-arithmetic reference: 64-bit integer products and truncating division.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] r, output bit wr);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        wr = 1'b1;
        r  = '0;
        case (op)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            2'b10: if (b == 0) wr = 1'b0; else r = {32'(sa % sb), 32'(sa / sb)};
            default: if (b == 0) wr = 1'b0; else r = {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDOp = op; A1 = a; A2 = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Called at the first negedge after launch; counts Busy cycles, checks HI/LO hold.
    task automatic wait_done(input int exp_n, input string name);
        int n = 0;
        while (Busy === 1'b1 && n < 64) begin
            n++;
            if (n == 1) begin
                check({name, " hold hi"}, Hi, m_hi);
                check({name, " hold lo"}, Lo, m_lo);
            end
            @(negedge clk);
        end
        check({name, " busy cycles"}, n, exp_n);
    endtask

    task automatic mt_write(input bit hw, input bit lw, input logic [31:0] d);
        HiWrite = hw; LoWrite = lw; A1 = d;
        @(negedge clk);
        HiWrite = 1'b0; LoWrite = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
    endtask

    vec_t tbl[8];

    initial begin
        logic [63:0] r;
        bit          wr;
        logic [1:0]  op;
        logic [31:0] a, b;

        tbl[0] = '{2'b00, 32'h8000_0000, 32'h2,         32'hFFFF_FFFF, 32'h0000_0000};
        tbl[1] = '{2'b01, 32'h8000_0000, 32'h2,         32'h0000_0001, 32'h0000_0000};
        tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'b11, 32'h7,         32'h2,         32'h0000_0001, 32'h0000_0003};
        tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[5] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        tbl[6] = '{2'b11, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF};
        tbl[7] = '{2'b10, 32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        reset_n = 1'b0; Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        MDOp = 2'b00; A1 = '0; A2 = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset hi", Hi, 32'd0);
        check("reset lo", Lo, 32'd0);

        // directed table
        for (int i = 0; i < 8; i++) begin
            start_op(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_done(tbl[i].op[1] ? DC : MC, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d hi", i), Hi, tbl[i].hi);
            check($sformatf("tbl%0d lo", i), Lo, tbl[i].lo);
            m_hi = tbl[i].hi; m_lo = tbl[i].lo;
        end

        // MTHI/MTLO preload then DIVU by zero leaves HI/LO
        mt_write(1'b1, 1'b0, 32'h1111);
        mt_write(1'b0, 1'b1, 32'h2222);
        check("mthi", Hi, 32'h1111);
        check("mtlo", Lo, 32'h2222);
        start_op(2'b11, 32'h1234, 32'h0);
        wait_done(DC, "divz");
        check("divz hi", Hi, 32'h1111);
        check("divz lo", Lo, 32'h2222);
        start_op(2'b10, 32'h1234, 32'h0);
        wait_done(DC, "sdivz");
        check("sdivz hi", Hi, 32'h1111);
        check("sdivz lo", Lo, 32'h2222);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
        check("mt both hi", Hi, 32'hCAFE_F00D);
        check("mt both lo", Lo, 32'hCAFE_F00D);

        // Start and LoWrite during Busy are ignored; back-to-back Start accepted
        start_op(2'b00, 32'd3, 32'd4);
        Start = 1'b1; MDOp = 2'b10; LoWrite = 1'b1; A1 = 32'h55; A2 = 32'h7;
        @(negedge clk);
        Start = 1'b0; LoWrite = 1'b0;
        wait_done(MC - 1, "busyign");
        check("busyign hi", Hi, 32'd0);
        check("busyign lo", Lo, 32'd12);
        m_hi = 32'd0; m_lo = 32'd12;
        start_op(2'b01, 32'd6, 32'd7);
        wait_done(MC, "b2b");
        check("b2b lo", Lo, 32'd42);
        m_lo = 32'd42;

        // reset in the middle of a DIV
        start_op(2'b10, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst busy", {31'd0, Busy}, 32'd0);
        check("midrst hi", Hi, 32'd0);
        check("midrst lo", Lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        check("postrst busy", {31'd0, Busy}, 32'd0);
        start_op(2'b11, 32'd100, 32'd7);
        wait_done(DC, "postrst");
        check("postrst hi", Hi, 32'd2);
        check("postrst lo", Lo, 32'd14);
        m_hi = 32'd2; m_lo = 32'd14;

        // Start and HiWrite together: Start wins
        mt_write(1'b1, 1'b0, 32'hABCD);
        HiWrite = 1'b1;
        start_op(2'b01, 32'd5, 32'd6);
        HiWrite = 1'b0;
        wait_done(MC, "startwin");
        check("startwin hi", Hi, 32'd0);
        check("startwin lo", Lo, 32'd30);
        m_hi = 32'd0; m_lo = 32'd30;

        // randomized ops against the model
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0)
                mt_write(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
            op = 2'($urandom_range(3));
            a  = $urandom;
            b  = ($urandom_range(7) == 0) ? 32'd0 :
                 ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
            if ($urandom_range(15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            model(op, a, b, r, wr);
            start_op(op, a, b);
            wait_done(op[1] ? DC : MC, $sformatf("rnd%0d", i));
            if (wr) begin m_hi = r[63:32]; m_lo = r[31:0]; end
            check($sformatf("rnd%0d hi", i), Hi, m_hi);
            check($sformatf("rnd%0d lo", i), Lo, m_lo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
